irq_ctrl: RTL and testbench



---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_sync_edge.sv | 30 +++
 rtl/irq_ctrl.sv | 156 +++++++++++++++
 tb/tb_irq_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the multi-source interrupt controller.
// Holds the FSM encoding, the register offsets and the priority-encoder helper.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } stateT;

    localparam logic [2:0] IRQ_EN     = 3'd0;
    localparam logic [2:0] IRQ_PEND   = 3'd1;
    localparam logic [2:0] IRQ_MODE   = 3'd2;
    localparam logic [2:0] IRQ_ACTIVE = 3'd3;
    localparam logic [2:0] IRQ_SWTRIG = 3'd4;

    // Lowest set index wins; an empty vector returns 0.
    function automatic logic [2:0] lowestSet(input logic [7:0] vec);
        lowestSet = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) lowestSet = 3'(i);
        end
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source flip-flop synchroniser followed by a rising-edge detector.
// SYNC_STAGES must be at least 2.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic syncLevel,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   syncD;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            syncD <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], asyncIn};
            syncD <= chain[SYNC_STAGES-1];
        end
    end

    assign syncLevel = chain[SYNC_STAGES-1];
    assign rise      = syncLevel & ~syncD;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: pending/mask/mode registers, priority select
// and a single in-service tracker in front of the CPU interrupt_0 pair.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NUM_SRC     = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h1080,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic [15:0]        io_addr,
    input  logic [7:0]         io_wdata,
    input  logic               io_we,
    input  logic               io_re,
    output logic [7:0]         io_rdata,
    output logic               irq_out,
    input  logic               irq_ack,
    output logic [2:0]         irq_id
);

    localparam logic [7:0] SRC_MASK = 8'((16'd1 << NUM_SRC) - 16'd1);

    logic [7:0] syncAll, riseAll;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : gSrc
            if (g < NUM_SRC) begin : gInst
                irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSync (
                    .clk       (clk),
                    .rst       (rst),
                    .asyncIn   (src_irq[g]),
                    .syncLevel (syncAll[g]),
                    .rise      (riseAll[g])
                );
            end else begin : gTie
                assign syncAll[g] = 1'b0;
                assign riseAll[g] = 1'b0;
            end
        end
    endgenerate

    stateT      state;
    logic [7:0] enReg, pendReg, modeReg;
    logic [2:0] activeId;

    logic [15:0] offset;
    logic        sel;
    logic [2:0]  regOff;
    logic        wrEn, wrPend, wrMode, wrActive, wrSwtrig;

    // Addresses below the base wrap to large offsets and fall outside the window.
    assign offset   = io_addr - BASE_ADDR;
    assign sel      = offset < 16'd5;
    assign regOff   = offset[2:0];
    assign wrEn     = io_we && sel && (regOff == IRQ_EN);
    assign wrPend   = io_we && sel && (regOff == IRQ_PEND);
    assign wrMode   = io_we && sel && (regOff == IRQ_MODE);
    assign wrActive = io_we && sel && (regOff == IRQ_ACTIVE);
    assign wrSwtrig = io_we && sel && (regOff == IRQ_SWTRIG);

    logic [7:0] reqVec, ackClr, edgeSet, edgeClr, pendNxt, enNxt, reqNxt;
    logic [2:0] winner;

    assign reqVec  = pendReg & enReg;
    assign winner  = lowestSet(reqVec);
    assign ackClr  = (state == REQ && irq_ack) ? ((8'd1 << winner) & modeReg) : 8'd0;
    assign edgeSet = riseAll | (wrSwtrig ? io_wdata : 8'd0);
    assign edgeClr = (wrPend ? io_wdata : 8'd0) | ackClr;

    // Any set beats any clear in edge mode; level mode just mirrors the synchronised line.
    always_comb begin
        // NOTE: default first so no path through the block leaves pendNxt unassigned (no latch).
        pendNxt = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (modeReg[i]) pendNxt[i] = edgeSet[i] | (pendReg[i] & ~edgeClr[i]);
            else            pendNxt[i] = syncAll[i];
        end
    end

    assign enNxt  = wrEn ? (io_wdata & SRC_MASK) : enReg;
    assign reqNxt = pendNxt & enNxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enReg    <= 8'd0;
            pendReg  <= 8'd0;
            modeReg  <= 8'd0;
            io_rdata <= 8'd0;
        end else begin
            enReg   <= enNxt;
            pendReg <= pendNxt;
            if (wrMode) modeReg <= io_wdata & SRC_MASK;
            if (io_re && sel) begin
                case (regOff)
                    IRQ_EN:     io_rdata <= enReg;
                    IRQ_PEND:   io_rdata <= pendReg;
                    IRQ_MODE:   io_rdata <= modeReg;
                    IRQ_ACTIVE: io_rdata <= {state == SERVICE, 4'b0000, activeId};
                    default:    io_rdata <= 8'd0;
                endcase
            end else begin
                io_rdata <= 8'd0;
            end
        end
    end

    // Looking at next-cycle request vector lets the registered irq_out/irq_id
    // drop and re-target in the same cycle the mask or pending bits change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            irq_out  <= 1'b0;
            irq_id   <= 3'd0;
            activeId <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqVec != 8'd0 && reqNxt != 8'd0) begin
                        state   <= REQ;
                        irq_out <= 1'b1;
                        irq_id  <= lowestSet(reqNxt);
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state    <= SERVICE;
                        irq_out  <= 1'b0;
                        irq_id   <= winner;
                        activeId <= winner;
                    end else if (reqNxt == 8'd0) begin
                        state   <= IDLE;
                        irq_out <= 1'b0;
                        irq_id  <= 3'd0;
                    end else begin
                        irq_id <= lowestSet(reqNxt);
                    end
                end
                SERVICE: begin
                    if (wrActive) begin
                        state  <= IDLE;
                        irq_id <= 3'd0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    irq_out <= 1'b0;
                    irq_id  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed expectations for the register map,
// edge/level pending, priority, masking, software trigger and reset.
module tb_irq_ctrl;
    import irq_pkg::*;

    localparam logic [15:0] BASE = 16'h1080;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  srcIrq;
    logic [15:0] ioAddr;
    logic [7:0]  ioWdata;
    logic        ioWe, ioRe;
    logic [7:0]  ioRdata;
    logic        irqOut, irqAck;
    logic [2:0]  irqId;

    int nCompared   = 0;
    int nMismatched = 0;

    irq_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .src_irq  (srcIrq),
        .io_addr  (ioAddr),
        .io_wdata (ioWdata),
        .io_we    (ioWe),
        .io_re    (ioRe),
        .io_rdata (ioRdata),
        .irq_out  (irqOut),
        .irq_ack  (irqAck),
        .irq_id   (irqId)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [2:0] off, input logic [7:0] data);
        ioAddr  = BASE + {13'd0, off};
        ioWdata = data;
        ioWe    = 1'b1;
        tick();
        ioWe    = 1'b0;
        ioWdata = 8'h00;
        ioAddr  = 16'h0000;
    endtask

    task automatic busRead(input logic [2:0] off, output logic [7:0] data);
        ioAddr = BASE + {13'd0, off};
        ioRe   = 1'b1;
        tick();
        data   = ioRdata;
        ioRe   = 1'b0;
        ioAddr = 16'h0000;
    endtask

    task automatic pulseAck();
        irqAck = 1'b1;
        tick();
        irqAck = 1'b0;
    endtask

    task automatic waitIrq(input string name);
        int n;
        n = 0;
        while (irqOut !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        nCompared++;
        if (irqOut !== 1'b1) begin
            nMismatched++;
            $display("FAIL %s_timeout: irq_out=%b, required 1 within 20 cycles", name, irqOut);
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            busRead(3'(i), rd);
            nCompared++;
            if (rd !== 8'h00) begin
                nMismatched++;
                $display("FAIL reset_read_off%0d: got %h, required 00", i, rd);
            end
        end
        nCompared++;
        if (irqOut !== 1'b0 || irqId !== 3'd0) begin
            nMismatched++;
            $display("FAIL reset_outputs: irq_out=%b irq_id=%0d, required 0/0", irqOut, irqId);
        end
    endtask

    task automatic test_edge_mode();
        logic [7:0] rd;
        busWrite(IRQ_EN, 8'h04);
        busWrite(IRQ_MODE, 8'h04);
        srcIrq[2] = 1'b1;
        tick();
        srcIrq[2] = 1'b0;
        tick();
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL edge_early_cycle2: irq_out=%b, required 0", irqOut);
        end
        tick();
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL edge_early_cycle3: irq_out=%b, required 0", irqOut);
        end
        tick();
        nCompared++;
        if (irqOut !== 1'b1 || irqId !== 3'd2) begin
            nMismatched++;
            $display("FAIL edge_request: irq_out=%b irq_id=%0d, required 1/2", irqOut, irqId);
        end
        busRead(IRQ_PEND, rd);
        nCompared++;
        if (rd !== 8'h04) begin
            nMismatched++;
            $display("FAIL edge_pend_set: got %h, required 04", rd);
        end
        pulseAck();
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL edge_ack_irq_out: irq_out=%b, required 0", irqOut);
        end
        busRead(IRQ_PEND, rd);
        nCompared++;
        if (rd !== 8'h00) begin
            nMismatched++;
            $display("FAIL edge_pend_after_ack: got %h, required 00", rd);
        end
        busRead(IRQ_ACTIVE, rd);
        nCompared++;
        if (rd !== 8'h82) begin
            nMismatched++;
            $display("FAIL edge_active_in_service: got %h, required 82", rd);
        end
        busWrite(IRQ_ACTIVE, 8'h00);
        busRead(IRQ_ACTIVE, rd);
        nCompared++;
        if (rd !== 8'h02) begin
            nMismatched++;
            $display("FAIL edge_active_after_eoi: got %h, required 02", rd);
        end
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL edge_irq_after_eoi: irq_out=%b, required 0", irqOut);
        end
    endtask

    task automatic test_level_priority();
        logic [7:0] rd;
        busWrite(IRQ_MODE, 8'h00);
        busWrite(IRQ_EN, 8'hFF);
        srcIrq = 8'h22;
        waitIrq("level_first");
        nCompared++;
        if (irqId !== 3'd1) begin
            nMismatched++;
            $display("FAIL level_priority_id: got %0d, required 1", irqId);
        end
        pulseAck();
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL level_ack_irq_out: irq_out=%b, required 0", irqOut);
        end
        busWrite(IRQ_ACTIVE, 8'h00);
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL level_eoi_same_cycle: irq_out=%b, required 0", irqOut);
        end
        tick();
        nCompared++;
        if (irqOut !== 1'b1 || irqId !== 3'd1) begin
            nMismatched++;
            $display("FAIL level_rerequest: irq_out=%b irq_id=%0d, required 1/1", irqOut, irqId);
        end
        srcIrq = 8'h20;
        for (int i = 0; i < 4; i++) tick();
        nCompared++;
        if (irqOut !== 1'b1 || irqId !== 3'd5) begin
            nMismatched++;
            $display("FAIL level_next_winner: irq_out=%b irq_id=%0d, required 1/5", irqOut, irqId);
        end
        pulseAck();
        busRead(IRQ_ACTIVE, rd);
        nCompared++;
        if (rd !== 8'h85) begin
            nMismatched++;
            $display("FAIL level_active_src5: got %h, required 85", rd);
        end
        srcIrq = 8'h00;
        for (int i = 0; i < 4; i++) tick();
        busWrite(IRQ_ACTIVE, 8'h00);
        tick();
        tick();
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL level_quiet_after_drop: irq_out=%b, required 0", irqOut);
        end
    endtask

    task automatic test_mask();
        logic [7:0] rd;
        busWrite(IRQ_EN, 8'h08);
        srcIrq = 8'h08;
        waitIrq("mask_first");
        nCompared++;
        if (irqId !== 3'd3) begin
            nMismatched++;
            $display("FAIL mask_req_id: got %0d, required 3", irqId);
        end
        busWrite(IRQ_EN, 8'h00);
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL mask_drop_same_cycle: irq_out=%b, required 0", irqOut);
        end
        tick();
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL mask_stays_idle: irq_out=%b, required 0", irqOut);
        end
        busRead(IRQ_ACTIVE, rd);
        nCompared++;
        if (rd !== 8'h05) begin
            nMismatched++;
            $display("FAIL mask_active_untouched: got %h, required 05", rd);
        end
        busWrite(IRQ_EN, 8'h08);
        waitIrq("mask_second");
        ioAddr  = BASE + {13'd0, IRQ_EN};
        ioWdata = 8'h00;
        ioWe    = 1'b1;
        irqAck  = 1'b1;
        tick();
        ioWe    = 1'b0;
        ioAddr  = 16'h0000;
        irqAck  = 1'b0;
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL mask_ack_irq_out: irq_out=%b, required 0", irqOut);
        end
        busRead(IRQ_ACTIVE, rd);
        nCompared++;
        if (rd !== 8'h83) begin
            nMismatched++;
            $display("FAIL mask_ack_wins: got %h, required 83", rd);
        end
        busWrite(IRQ_ACTIVE, 8'h00);
        srcIrq = 8'h00;
        tick();
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL mask_after_eoi: irq_out=%b, required 0", irqOut);
        end
    endtask

    task automatic test_swtrig();
        logic [7:0] rd;
        busWrite(IRQ_MODE, 8'h01);
        busWrite(IRQ_EN, 8'h01);
        busWrite(IRQ_SWTRIG, 8'h01);
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL swtrig_latency: irq_out=%b, required 0", irqOut);
        end
        tick();
        nCompared++;
        if (irqOut !== 1'b1 || irqId !== 3'd0) begin
            nMismatched++;
            $display("FAIL swtrig_request: irq_out=%b irq_id=%0d, required 1/0", irqOut, irqId);
        end
        srcIrq[0] = 1'b1;
        tick();
        tick();
        busWrite(IRQ_PEND, 8'h01);
        busRead(IRQ_PEND, rd);
        nCompared++;
        if (rd !== 8'h01) begin
            nMismatched++;
            $display("FAIL swtrig_set_beats_w1c: got %h, required 01", rd);
        end
        nCompared++;
        if (irqOut !== 1'b1) begin
            nMismatched++;
            $display("FAIL swtrig_still_req: irq_out=%b, required 1", irqOut);
        end
        busWrite(IRQ_PEND, 8'h01);
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL swtrig_w1c_drop: irq_out=%b, required 0", irqOut);
        end
        busRead(IRQ_PEND, rd);
        nCompared++;
        if (rd !== 8'h00) begin
            nMismatched++;
            $display("FAIL swtrig_w1c_clear: got %h, required 00", rd);
        end
        srcIrq = 8'h00;
    endtask

    task automatic test_reset_in_service();
        logic [7:0] rd;
        busWrite(IRQ_MODE, 8'h04);
        busWrite(IRQ_EN, 8'h04);
        busWrite(IRQ_SWTRIG, 8'h04);
        waitIrq("rst_req");
        pulseAck();
        ioAddr = BASE + {13'd0, IRQ_ACTIVE};
        ioRe   = 1'b1;
        tick();
        nCompared++;
        if (ioRdata !== 8'h82 || irqId !== 3'd2) begin
            nMismatched++;
            $display("FAIL rst_pre_service: rdata=%h irq_id=%0d, required 82/2", ioRdata, irqId);
        end
        #2 rst = 1'b1;
        #1;
        nCompared++;
        if (ioRdata !== 8'h00 || irqOut !== 1'b0 || irqId !== 3'd0) begin
            nMismatched++;
            $display("FAIL rst_immediate: rdata=%h irq_out=%b irq_id=%0d, required 00/0/0",
                     ioRdata, irqOut, irqId);
        end
        ioRe   = 1'b0;
        ioAddr = 16'h0000;
        #2 rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            busRead(3'(i), rd);
            nCompared++;
            if (rd !== 8'h00) begin
                nMismatched++;
                $display("FAIL rst_reg_off%0d: got %h, required 00", i, rd);
            end
        end
        pulseAck();
        nCompared++;
        if (irqOut !== 1'b0) begin
            nMismatched++;
            $display("FAIL rst_ack_ignored_irq: irq_out=%b, required 0", irqOut);
        end
        busRead(IRQ_ACTIVE, rd);
        nCompared++;
        if (rd !== 8'h00) begin
            nMismatched++;
            $display("FAIL rst_ack_ignored_active: got %h, required 00", rd);
        end
    endtask

    initial begin
        rst     = 1'b1;
        srcIrq  = 8'h00;
        ioAddr  = 16'h0000;
        ioWdata = 8'h00;
        ioWe    = 1'b0;
        ioRe    = 1'b0;
        irqAck  = 1'b0;

        test_reset();
        test_edge_mode();
        test_level_priority();
        test_mask();
        test_swtrig();
        test_reset_in_service();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
